// File: rtl/apb_bridge_mux.sv
// APB4 bridge: turns one valid/ready MMIO request into a SETUP/ACCESS transfer on the decoded slave.
// Decode misses and ACCESS timeouts complete locally with an error response.
module apb_bridge_mux #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SLV    = 4,
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_MASK = '0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic                          req_write,
  input  logic [DATA_WIDTH-1:0]         req_wdata,
  input  logic [DATA_WIDTH/8-1:0]       req_strb,
  input  logic [2:0]                    req_prot,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_rdata,
  output logic                          resp_err,
  output logic [ADDR_WIDTH-1:0]         apb_paddr,
  output logic [2:0]                    apb_pprot,
  output logic                          apb_pwrite,
  output logic [DATA_WIDTH-1:0]         apb_pwdata,
  output logic [DATA_WIDTH/8-1:0]       apb_pstrb,
  output logic                          apb_penable,
  output logic [NUM_SLV-1:0]            apb_psel,
  input  logic [NUM_SLV-1:0]            apb_pready,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] apb_prdata,
  input  logic [NUM_SLV-1:0]            apb_pslverr
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                  state_q;
  logic [NUM_SLV-1:0]      psel_q;
  logic                    penable_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [2:0]              pprot_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [DATA_WIDTH/8-1:0] pstrb_q;
  logic                    resp_valid_q;
  logic                    resp_err_q;
  logic [DATA_WIDTH-1:0]   resp_rdata_q;
  logic [31:0]             cnt_q;

  logic [NUM_SLV-1:0]      hit_sel;
  logic                    hit_any;
  logic                    sel_pready;
  logic                    sel_pslverr;
  logic [DATA_WIDTH-1:0]   sel_prdata;
  logic                    timeout_hit;

  // Priority decode: the first (lowest-index) matching slot claims the request.
  always_comb begin
    hit_sel = '0;
    hit_any = 1'b0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (!hit_any && ((req_addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                       SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit_sel[i] = 1'b1;
        hit_any    = 1'b1;
      end
    end
  end

  always_comb begin
    sel_pready  = 1'b0;
    sel_pslverr = 1'b0;
    sel_prdata  = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (psel_q[i]) begin
        sel_pready  = apb_pready[i];
        sel_pslverr = apb_pslverr[i];
        sel_prdata  = apb_prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      psel_q       <= '0;
      penable_q    <= 1'b0;
      paddr_q      <= '0;
      pprot_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      cnt_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            paddr_q  <= req_addr;
            pprot_q  <= req_prot;
            pwrite_q <= req_write;
            pwdata_q <= req_wdata;
            pstrb_q  <= req_write ? req_strb : '0;
            if (hit_any) begin
              psel_q  <= hit_sel;
              state_q <= StSetup;
            end else begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
              state_q      <= StResp;
            end
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= StAccess;
        end
        StAccess: begin
          // A pready in the timeout cycle still completes the transfer normally.
          if (sel_pready) begin
            psel_q       <= '0;
            penable_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= sel_pslverr;
            resp_rdata_q <= (pwrite_q || sel_pslverr) ? '0 : sel_prdata;
            state_q      <= StResp;
          end else if (timeout_hit) begin
            psel_q       <= '0;
            penable_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
            state_q      <= StResp;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  assign apb_paddr   = paddr_q;
  assign apb_pprot   = pprot_q;
  assign apb_pwrite  = pwrite_q;
  assign apb_pwdata  = pwdata_q;
  assign apb_pstrb   = pstrb_q;
  assign apb_penable = penable_q;
  assign apb_psel    = psel_q;

endmodule
